// File: rtl/boa_div_iter.sv
// boa_div_iter -- iterative restoring divider, signed or unsigned.
//
// Resolves `unroll` quotient bits per clock. It takes N = width/unroll CALC
// cycles, then one FIX cycle that applies the signs, then the result is held
// in DONE until the consumer takes it. A divide by zero skips CALC/FIX. It
// goes straight to DONE with an all-ones quotient and the dividend as the
// remainder.
//
// Parameters
//   width   operand/result width (>= 2)
//   unroll  quotient bits per cycle (must divide width)
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous cancel; blocks any accept that cycle
//   d_valid/d_ready    operand handshake (u, lhs, rhs)
//   u                  1 = unsigned, 0 = two's complement
//   lhs, rhs           dividend, divisor
//   q_valid/q_ready    result handshake (div_res, mod_res)
//   div_res, mod_res   quotient (truncated toward zero), remainder (sign of lhs)

// One restoring step: shift the next dividend bit into the partial remainder.
// Subtract the divisor if it fits, and shift the resulting quotient bit into quo.
module boa_div_step #(
  parameter int width = 32
) (
  input  logic [width-1:0] rem_cur,
  input  logic [width-1:0] quo_cur,
  input  logic [width-1:0] dvs,
  output logic [width-1:0] rem_nxt,
  output logic [width-1:0] quo_nxt
);
  logic [width:0] trial;
  logic [width:0] diff;
  logic           fits;

  // The partial remainder is always < dvs, so trial < 2*dvs.
  // Whichever branch is taken, the new remainder fits in width bits.
  assign trial   = {rem_cur, quo_cur[width-1]};
  assign diff    = trial - {1'b0, dvs};
  assign fits    = ~diff[width];
  assign rem_nxt = fits ? diff[width-1:0] : trial[width-1:0];
  assign quo_nxt = {quo_cur[width-2:0], fits};
endmodule

module boa_div_iter #(
  parameter int width  = 32,
  parameter int unroll = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             u,
  input  logic [width-1:0] lhs,
  input  logic [width-1:0] rhs,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [width-1:0] div_res,
  output logic [width-1:0] mod_res
);
  localparam int N  = width / unroll;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N = CW'(N);
  localparam logic [CW-1:0] CNT_1 = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [width-1:0] rem;      // partial remainder
  logic [width-1:0] quo;      // dividend bits shift out, quotient bits shift in
  logic [width-1:0] dvs;      // divisor magnitude
  logic            neg_q;
  logic            neg_r;

  logic             accept;
  logic             lhs_neg, rhs_neg, rhs_zero;
  logic [width-1:0] lhs_mag, rhs_mag;
  logic [width-1:0] rem_step, quo_step;

  // ---------------------------------------------------------------- handshake
  assign d_ready = (state == IDLE) || ((state == DONE) && q_ready);
  assign q_valid = (state == DONE);
  assign accept  = d_valid && d_ready && !flush;

  // ------------------------------------------------------- operand conditioning
  // The magnitude of the most-negative value is the same bit pattern read
  // as unsigned. That lets the overflow case flow through CALC/FIX unchanged.
  assign lhs_neg  = !u && lhs[width-1];
  assign rhs_neg  = !u && rhs[width-1];
  assign lhs_mag  = lhs_neg ? -lhs : lhs;
  assign rhs_mag  = rhs_neg ? -rhs : rhs;
  assign rhs_zero = (rhs == '0);

  // --------------------------------------------------------- unrolled stepping
  for (genvar g = 0; g < unroll; g++) begin : g_step
    logic [width-1:0] rem_pre, quo_pre, rem_post, quo_post;

    if (g == 0) begin : g_head
      assign rem_pre = rem;
      assign quo_pre = quo;
    end else begin : g_link
      assign rem_pre = g_step[g-1].rem_post;
      assign quo_pre = g_step[g-1].quo_post;
    end

    boa_div_step #(.width(width)) u_step (
      .rem_cur (rem_pre),
      .quo_cur (quo_pre),
      .dvs     (dvs),
      .rem_nxt (rem_post),
      .quo_nxt (quo_post)
    );
  end

  assign rem_step = g_step[unroll-1].rem_post;
  assign quo_step = g_step[unroll-1].quo_post;

  // ---------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = rhs_zero ? DONE : CALC;
        CALC: if (count == CNT_1) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: if (q_ready) begin
                // retire; a same-cycle accept starts the next op with no bubble
                if (accept) state_nxt = rhs_zero ? DONE : CALC;
                else        state_nxt = IDLE;
              end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div_res <= '0;
      mod_res <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (accept) begin
      neg_q <= lhs_neg ^ rhs_neg;
      neg_r <= lhs_neg;
      if (rhs_zero) begin
        count   <= '0;
        div_res <= '1;
        mod_res <= lhs;
      end else begin
        count <= CNT_N;
        rem   <= '0;
        quo   <= lhs_mag;
        dvs   <= rhs_mag;
      end
    end else if (state == CALC) begin
      count <= count - CNT_1;
      rem   <= rem_step;
      quo   <= quo_step;
    end else if (state == FIX) begin
      div_res <= neg_q ? -quo : quo;
      mod_res <= neg_r ? -rem : rem;
    end
  end
endmodule

// File: doc/boa_div_iter.md
BOA_DIV_ITER -- requirements
Module: boa_div_iter

Interface
REQ-001 Parameter width, default 32: operand and result bit width; SHALL be >= 2.
REQ-002 Parameter unroll, default 1: quotient bits resolved per cycle; SHALL divide width evenly.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous cancel of any operation in progress.
REQ-006 d_valid  input  1  operands and mode valid.
REQ-007 d_ready  output  1  block accepts operands this cycle.
REQ-008 u  input  1  unsigned division when 1, signed two's complement when 0.
REQ-009 lhs  input  width  dividend.
REQ-010 rhs  input  width  divisor.
REQ-011 q_valid  output  1  div_res and mod_res valid.
REQ-012 q_ready  input  1  consumer accepts the result.
REQ-013 div_res  output  width  quotient.
REQ-014 mod_res  output  width  remainder.

Function
REQ-015 States SHALL be IDLE, CALC, FIX and DONE; N = width/unroll.
REQ-016 An accept SHALL occur on a rising edge with d_valid && d_ready && !flush; operands and u are captured at that edge.
REQ-017 d_ready SHALL be 1 in IDLE, 1 in DONE while q_ready=1, and 0 otherwise.
REQ-018 On accept with rhs != 0: next state CALC; magnitudes |lhs| and |rhs| (signed mode) or raw values (unsigned mode) are latched; count is set to N.
REQ-019 CALC SHALL perform unroll restoring-division steps per cycle, MSB first, decrementing count; after N CALC cycles it SHALL go to FIX.
REQ-020 FIX SHALL negate the quotient when signed and sign(lhs) != sign(rhs), negate the remainder when signed and lhs negative, then go to DONE.
REQ-021 On accept with rhs == 0: next state DONE directly; div_res = all ones, mod_res = lhs unmodified, in both modes.
REQ-022 Signed overflow (lhs = most-negative, rhs = -1) SHALL yield div_res = lhs and mod_res = 0 through the normal CALC/FIX path.
REQ-023 Latency: q_valid SHALL rise N+2 edges after the accept edge (N CALC + 1 FIX + entry to DONE); for a divide by zero, 1 edge after the accept edge.
REQ-024 q_valid SHALL be 1 exactly in DONE; div_res and mod_res SHALL hold stable while q_valid=1 && q_ready=0.
REQ-025 DONE with q_ready=1 and no new accept: next state IDLE.
REQ-026 DONE with q_ready=1 and a new accept in the same cycle: the result retires and the new operation starts (CALC or DONE) with no idle bubble.
REQ-027 flush=1 SHALL force next state IDLE from any state, discard any pending result, and block an accept in that cycle.
REQ-028 Outside DONE, div_res and mod_res values are don't-care, but SHALL NOT be X after reset.
REQ-029 The quotient SHALL equal the truncation toward zero; the remainder SHALL take the sign of the dividend; lhs = div_res*rhs + mod_res (mod 2^width) for all rhs != 0.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, count 0, q_valid 0, div_res 0 and mod_res 0, and d_ready 1 after reset release.
REQ-031 Reset asserted mid-CALC SHALL abandon the operation with no result ever presented.

Verification (width=32, unroll=1 unless noted)
REQ-032 Unsigned 100/7, q_ready=1 -> q_valid rises at accept+34 edges with div_res=14, mod_res=2, then IDLE.
REQ-033 Signed -7/2 -> div_res=0xFFFFFFFD, mod_res=0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> div_res=0x80000000, mod_res=0.
REQ-034 Divide by zero: signed lhs=-5, rhs=0 -> q_valid after 1 edge, div_res=0xFFFFFFFF, mod_res=0xFFFFFFFB.
REQ-035 Backpressure: q_ready=0 for 5 cycles in DONE -> outputs stable and d_ready=0; then q_ready=1 with d_valid=1 -> back-to-back accept, second result correct.
REQ-036 flush asserted at CALC cycle 10, then rst_n pulsed low during a later CALC -> IDLE each time, no q_valid, next operation 1000/10 yields 100 rem 0.
REQ-037 unroll=4: 0xFFFFFFFF/3 unsigned -> q_valid at accept+10 edges, div_res=0x55555555, mod_res=0; random signed/unsigned sweep matches reference model per REQ-029.
